// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: launches/resumes fetch, hands instructions to decode, steers the PC.
// Optional fetch watchdog built when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic [31:0] pc_value,
    output logic        pc_cnt_en,
    output logic        pc_load_en,
    output logic [31:0] pc_load_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // state   | meaning
    // IDLE    | out of reset, waiting for start (loads RESET_VECTOR)
    // FETCH   | imem request outstanding at pc_value
    // DELIVER | instruction presented to decode until accepted
    // HALT    | stopped; start resumes at current pc_value unless faulted
    typedef enum logic [1:0] {IDLE, FETCH, DELIVER, HALT} state_t;

    state_t state, state_next;
    logic   halt_pending;
    logic   handoff;
    logic   wd_expire;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES out of range 2..255");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wd_cnt;

    assign wd_expire = (state == FETCH) && !imem_ack && ((wd_cnt + 8'd1) == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= 8'd0;
            fault  <= 1'b0;
        end else begin
            if (state == FETCH && !imem_ack && !wd_expire)
                wd_cnt <= wd_cnt + 8'd1;
            else
                wd_cnt <= 8'd0;
            if (wd_expire)
                fault <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign fault     = 1'b0;
`endif

    // Strobes are gated by rst so inputs have no effect while reset is held.
    always_comb begin
        state_next  = state;
        pc_cnt_en   = 1'b0;
        pc_load_en  = 1'b0;
        pc_load_val = 32'd0;
        handoff     = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc_load_en  = 1'b1;
                        pc_load_val = RESET_VECTOR;
                        state_next  = FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack)
                        state_next = DELIVER;
                    else if (wd_expire)
                        state_next = HALT;
                end
                DELIVER: begin
                    if (instr_ready) begin
                        handoff = 1'b1;
                        if (branch_valid) begin
                            pc_load_en  = 1'b1;
                            pc_load_val = branch_target;
                        end else begin
                            pc_cnt_en = 1'b1;
                        end
                        state_next = (halt_req || halt_pending) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    if (start && !fault)
                        state_next = FETCH;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            halt_pending <= 1'b0;
            instr        <= 32'd0;
            fetch_count  <= 32'd0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ack)
                instr <= imem_rdata;
            if (handoff)
                fetch_count <= fetch_count + 32'd1;
            if (state == HALT && start && !fault)
                halt_pending <= 1'b0;
            else if (halt_req && (state == FETCH || state == DELIVER))
                halt_pending <= 1'b1;
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = imem_req ? pc_value : 32'd0;
    assign instr_valid = (state == DELIVER);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; the PC register lives here.
// Watchdog case runs only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt_req;
    logic [31:0] pc_value;
    logic        pc_cnt_en, pc_load_en;
    logic [31:0] pc_load_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready, branch_valid;
    logic [31:0] branch_target;
    logic        halted, fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_VECTOR  (32'h0000_0100),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt_req     (halt_req),
        .pc_value     (pc_value),
        .pc_cnt_en    (pc_cnt_en),
        .pc_load_en   (pc_load_en),
        .pc_load_val  (pc_load_val),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halted       (halted),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    // PC register driven by the sequencer strobes.
    always @(posedge clk) begin
        if (pc_load_en)
            pc_value <= pc_load_val;
        else if (pc_cnt_en)
            pc_value <= pc_value + 32'd4;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_outs"}, {24'd0, pc_cnt_en, pc_load_en, imem_req, instr_valid,
                                   halted, fault, 2'b00}, 32'd0);
        check_val({tag, "_ldval"}, pc_load_val, 32'd0);
        check_val({tag, "_addr"}, imem_addr, 32'd0);
        check_val({tag, "_instr"}, instr, 32'd0);
        check_val({tag, "_cnt"}, fetch_count, 32'd0);
    endtask

    initial begin
        int n;
        pc_value      = 32'h0000_0000;
        rst           = 1'b0;
        start         = 1'b1;
        halt_req      = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 32'd0;
        repeat (3) tick();
        check_all_zero("reset");

        // Launch from IDLE
        rst = 1'b1;
        #1;
        check_val("launch_load_en", {31'd0, pc_load_en}, 32'd1);
        check_val("launch_load_val", pc_load_val, 32'h100);
        check_val("launch_cnt_en", {31'd0, pc_cnt_en}, 32'd0);
        tick();
        start = 1'b0;
        #1;
        check_val("fetch_load_en", {31'd0, pc_load_en}, 32'd0);
        check_val("fetch_req", {31'd0, imem_req}, 32'd1);
        check_val("fetch_addr", imem_addr, 32'h100);

        // Ack in first FETCH cycle, decode stalls one cycle
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check_val("deliver_valid", {31'd0, instr_valid}, 32'd1);
        check_val("deliver_instr", instr, 32'hDEAD_BEEF);
        check_val("deliver_req", {31'd0, imem_req}, 32'd0);
        check_val("stall_cnt_en", {31'd0, pc_cnt_en}, 32'd0);
        tick();
        check_val("stall_instr", instr, 32'hDEAD_BEEF);
        instr_ready = 1'b1;
        #1;
        check_val("handoff_cnt_en", {31'd0, pc_cnt_en}, 32'd1);
        check_val("handoff_load_en", {31'd0, pc_load_en}, 32'd0);
        tick();
        instr_ready = 1'b0;
        check_val("count_1", fetch_count, 32'd1);
        check_val("fetch2_addr", imem_addr, 32'h104);

        // Branch in FETCH ignored, branch at handoff loads target
        branch_valid  = 1'b1;
        branch_target = 32'h80;
        #1;
        check_val("fetch_branch_load", {31'd0, pc_load_en}, 32'd0);
        tick();
        branch_valid = 1'b0;
        check_val("fetch_branch_addr", imem_addr, 32'h104);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        tick();
        imem_ack      = 1'b0;
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'h40;
        #1;
        check_val("branch_load_en", {31'd0, pc_load_en}, 32'd1);
        check_val("branch_load_val", pc_load_val, 32'h40);
        check_val("branch_cnt_en", {31'd0, pc_cnt_en}, 32'd0);
        tick();
        instr_ready  = 1'b0;
        branch_valid = 1'b0;
        check_val("branch_addr", imem_addr, 32'h40);
        check_val("count_2", fetch_count, 32'd2);

        // halt_req mid-FETCH: deliver then HALT, resume without reload
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_val("halt_still_fetch", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 1'b0;
        check_val("halt_deliver_instr", instr, 32'hCAFE_F00D);
        instr_ready = 1'b1;
        #1;
        check_val("halt_handoff_cnt", {31'd0, pc_cnt_en}, 32'd1);
        tick();
        instr_ready = 1'b0;
        check_val("halted_flag", {31'd0, halted}, 32'd1);
        check_val("halted_req", {31'd0, imem_req}, 32'd0);
        check_val("halted_strobes", {30'd0, pc_cnt_en, pc_load_en}, 32'd0);
        check_val("count_3", fetch_count, 32'd3);
        tick();
        check_val("halted_hold", {31'd0, halted}, 32'd1);
        start = 1'b1;
        #1;
        check_val("resume_no_load", {31'd0, pc_load_en}, 32'd0);
        tick();
        start = 1'b0;
        check_val("resume_halted", {31'd0, halted}, 32'd0);
        check_val("resume_req", {31'd0, imem_req}, 32'd1);
        check_val("resume_addr", imem_addr, 32'h44);

        // Reset mid-FETCH
        rst = 1'b0;
        tick();
        check_all_zero("midrst");
        rst = 1'b1;
        tick();
        check_val("post_rst_idle", {31'd0, imem_req}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            tick();
        end
        check_val("timeout_cycles", n, 32'd16);
        check_val("timeout_fault", {31'd0, fault}, 32'd1);
        check_val("timeout_halted", {31'd0, halted}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("fault_start_ign", {30'd0, halted, imem_req}, 32'd2);
        rst = 1'b0;
        tick();
        check_val("fault_cleared", {31'd0, fault}, 32'd0);
        rst = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on start from IDLE.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: fetch watchdog limit, range 2..255, used only under FETCH_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  launch from IDLE, or resume from HALT.
REQ-006 halt_req  in  1  request stop after the next delivered instruction.
REQ-007 pc_value  in  32  current program counter value.
REQ-008 pc_cnt_en  out  1  PC increment strobe, one cycle.
REQ-009 pc_load_en  out  1  PC load strobe, one cycle.
REQ-010 pc_load_val  out  32  PC load value, valid while pc_load_en=1, otherwise 0.
REQ-011 imem_req  out  1  instruction memory request.
REQ-012 imem_addr  out  32  request address, equal to pc_value while imem_req=1, otherwise 0.
REQ-013 imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
REQ-014 imem_rdata  in  32  fetched word.
REQ-015 instr_valid / instr  out  1 / 32  delivered instruction to decode.
REQ-016 instr_ready  in  1  decode accepts the instruction.
REQ-017 branch_valid / branch_target  in  1 / 32  redirect the PC at handoff.
REQ-018 halted / fault  out  1 / 1  status flags.
REQ-019 fetch_count  out  32  number of delivered instructions.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DELIVER and HALT, one-hot or binary, with no other reachable state.
REQ-021 IDLE: when start=1, the block SHALL assert pc_load_en with pc_load_val=RESET_VECTOR for that cycle and move to FETCH.
REQ-022 FETCH: imem_req=1 and imem_addr=pc_value; when imem_ack=1, the block SHALL register imem_rdata into instr, drop imem_req the next cycle and move to DELIVER. An ack in the first FETCH cycle is legal.
REQ-023 DELIVER: instr_valid=1 with instr held stable until instr_ready=1.
REQ-024 Handoff is the DELIVER cycle with instr_ready=1. At handoff, branch_valid=1 SHALL pulse pc_load_en with pc_load_val=branch_target; otherwise pc_cnt_en=1. Both strobes SHALL never be high in the same cycle.
REQ-025 branch_valid SHALL be ignored outside handoff cycles.
REQ-026 After handoff, the next state SHALL be HALT if halt_req=1 or halt_pending=1, otherwise FETCH.
REQ-027 halt_req=1 in FETCH or DELIVER SHALL set halt_pending; the outstanding fetch completes and its instruction is delivered before HALT. halt_req in IDLE or HALT SHALL be ignored.
REQ-028 HALT: halted=1, and no strobes or requests are issued. start=1 with fault=0 SHALL clear halt_pending and move to FETCH without reloading the PC (resume at pc_value).
REQ-029 fetch_count SHALL increment by 1 at each handoff and wrap from 32'hFFFF_FFFF to 0.
REQ-030 pc_cnt_en and pc_load_en SHALL be combinational from state and inputs; all other outputs SHALL be registered or decoded from state.

Reset
REQ-031 rst=0 at a rising edge, in any state including mid-fetch, SHALL force IDLE and clear halt_pending, fault, the watchdog counter, instr and fetch_count. Every output SHALL be 0 from the following cycle.
REQ-032 While rst=0, all inputs SHALL be ignored.

Configuration
REQ-033 With macro FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL count FETCH cycles without imem_ack and reset to 0 on ack or on leaving FETCH.
REQ-034 Under FETCH_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES, the block SHALL set fault=1 (sticky until reset), drop imem_req and enter HALT; start SHALL then be ignored.
REQ-035 Without FETCH_TIMEOUT_EN, fault SHALL be constant 0, no counter is built, and FETCH waits indefinitely.

Verification
REQ-036 Reset release, start=1 with RESET_VECTOR=0x100 -> pc_load_en=1 and pc_load_val=0x100 for 1 cycle; next cycle imem_req=1 with imem_addr=pc_value.
REQ-037 Ack in the first FETCH cycle with rdata=0xDEADBEEF, instr_ready=1 -> instr_valid=1 with instr=0xDEADBEEF, then pc_cnt_en pulses once and fetch_count=1.
REQ-038 Handoff with branch_valid=1 and target 0x40 -> pc_load_en=1, pc_load_val=0x40, pc_cnt_en=0; branch_valid pulsed during FETCH has no effect.
REQ-039 halt_req pulsed mid-FETCH -> that instruction is delivered, then HALT with halted=1; start -> FETCH at an unchanged pc_value with no load strobe.
REQ-040 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> fault=1 and HALT after 16 FETCH cycles; start is ignored; rst=0 clears the fault. A separate case asserts rst=0 mid-FETCH -> IDLE with all outputs 0.
